// File: rtl/pipe_control.sv
// Hazard and exception control for a five-stage Y86-style pipeline.
// Produces per-register write enables and bubble requests, and counts stall and bubble events.
module pipe_control #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_we,
    output logic             D_we,
    output logic             E_we,
    output logic             M_we,
    output logic             W_we,
    output logic             D_rst,
    output logic             E_rst,
    output logic             M_rst,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_POPL   = 4'hB;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [2:0] S_AOK    = 3'd1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic load_use, ret_pend, mispredict, exc_m, exc_w, run;
    logic stall_evt, bubble_evt;

    always_comb begin
        load_use   = ((E_icode == I_MRMOVL) || (E_icode == I_POPL)) &&
                     (E_dstM != R_NONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        ret_pend   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispredict = (E_icode == I_JXX) && !e_Cnd;
        exc_m      = (m_stat != S_AOK);
        exc_w      = (W_stat != S_AOK);
        run        = (state_q == ST_RUN);
    end

    // A bubble is masked whenever the same register is stalled, so we=0 and rst=1 never coexist.
    always_comb begin
        F_we  = 1'b0;
        D_we  = 1'b0;
        E_we  = 1'b0;
        M_we  = 1'b0;
        W_we  = 1'b0;
        D_rst = 1'b0;
        E_rst = 1'b0;
        M_rst = 1'b0;
        if (run) begin
            F_we  = !(load_use || ret_pend);
            D_we  = !load_use;
            E_we  = 1'b1;
            M_we  = 1'b1;
            W_we  = !exc_w;
            D_rst = (mispredict || ret_pend) && D_we;
            E_rst = (mispredict || load_use) && E_we;
            M_rst = (exc_m || exc_w) && M_we;
        end
    end

    always_comb begin
        stall_evt    = run && (!F_we || !D_we);
        bubble_evt   = run && (D_rst || E_rst || M_rst);
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (run && exc_w) begin
            state_d = ST_HALTED;
        end
        if (stall_evt && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (bubble_evt && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign halted     = (state_q == ST_HALTED);
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
